// File: rtl/dot_product_pkg.sv
// Shared types, widths and address helper for the dot-product sequencer and its MAC.
package dot_product_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int VEC_LEN     = 8;
  localparam int NUM_VECTORS = 4;
  localparam int ADDR_WIDTH  = 5;
  localparam int SEL_WIDTH   = $clog2(NUM_VECTORS);
  localparam int IDX_WIDTH   = $clog2(VEC_LEN);
  localparam int RES_WIDTH   = 2 * DATA_WIDTH + $clog2(VEC_LEN);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    MAC,
    DONE
  } state_t;

  // First memory word of the selected vector.
  function automatic logic [ADDR_WIDTH-1:0] base(input logic [SEL_WIDTH-1:0] sel);
    return ADDR_WIDTH'(sel) * ADDR_WIDTH'(VEC_LEN);
  endfunction

endpackage

// File: rtl/dot_product_ctrl_if.sv
// Vector-memory port owned by the sequencer: gated write enable plus the read port.
interface dot_product_ctrl_if;
  import dot_product_pkg::*;

  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_wr_en,
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data
  );

  modport slave (
    input  mem_wr_en,
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data
  );

endinterface

// File: rtl/dot_mac.sv
// Registered multiply-accumulate with clear and enable.
// Define DOT_PRODUCT_SIGNED_EN for two's-complement operands; default is unsigned.
module dot_mac
  import dot_product_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [RES_WIDTH-1:0]  acc
);

  logic [RES_WIDTH-1:0] prod_ext;

`ifdef DOT_PRODUCT_SIGNED_EN
  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    prod     = $signed(a) * $signed(b);
    prod_ext = {{(RES_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  end
`else
  logic [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    prod     = a * b;
    prod_ext = {{(RES_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
  end
`endif

  // The accumulator is wide enough for VEC_LEN full-scale products, so it wraps never.
  always_ff @(posedge clk) begin
    if (!rst_n)      acc <= '0;
    else if (clr)    acc <= '0;
    else if (en)     acc <= acc + prod_ext;
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequencer that reads two vectors from the shared memory, accumulates their dot
// product and gates host writes while busy. Option macro: DOT_PRODUCT_SIGNED_EN.
module dot_product_ctrl
  import dot_product_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] vec_a_sel,
  input  logic [SEL_WIDTH-1:0] vec_b_sel,
  input  logic                 host_wr_en,
  output logic                 wr_rejected,
  output logic                 busy,
  output logic                 done,
  output logic [RES_WIDTH-1:0] result,
  dot_product_ctrl_if.master   mem
);

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(VEC_LEN - 1);

  state_t                state;
  logic [SEL_WIDTH-1:0]  a_sel;
  logic [SEL_WIDTH-1:0]  b_sel;
  logic [IDX_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] op_a;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [RES_WIDTH-1:0]  acc;
  logic                  accept;

  assign accept          = (state == IDLE) && start;
  assign mem.mem_wr_en   = host_wr_en & ~busy;
  assign mem.mem_rd_en   = rd_en_q;
  assign mem.mem_rd_addr = rd_addr_q;

  dot_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == MAC),
    .a     (op_a),
    .b     (mem.mem_rd_data),
    .acc   (acc)
  );

  // Read address/enable are registered one state ahead so each memory word arrives
  // in the state that consumes it: A data in RD_B, B data in MAC.
  // NOTE: all state here uses non-blocking assignments so every branch reads the
  // pre-edge values; a blocking write would leak into later reads in the same block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_rejected <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      result      <= '0;
      idx         <= '0;
      a_sel       <= '0;
      b_sel       <= '0;
      op_a        <= '0;
    end else begin
      done        <= 1'b0;
      wr_rejected <= host_wr_en & busy;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sel     <= vec_a_sel;
            b_sel     <= vec_b_sel;
            idx       <= '0;
            busy      <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= base(vec_a_sel);
            state     <= RD_A;
          end
        end
        RD_A: begin
          rd_addr_q <= base(b_sel) + ADDR_WIDTH'(idx);
          state     <= RD_B;
        end
        RD_B: begin
          op_a    <= mem.mem_rd_data;
          rd_en_q <= 1'b0;
          state   <= MAC;
        end
        MAC: begin
          if (idx == IDX_LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx       <= idx + 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= base(a_sel) + ADDR_WIDTH'(idx + 1'b1);
            state     <= RD_A;
          end
        end
        DONE: begin
          result <= acc;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: behavioural memory, reference dot product
// computed from a shadow copy of the memory contents.
module tb_dot_product_ctrl;
  import dot_product_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [SEL_WIDTH-1:0]  vec_a_sel;
  logic [SEL_WIDTH-1:0]  vec_b_sel;
  logic                  host_wr_en;
  logic                  wr_rejected;
  logic                  busy;
  logic                  done;
  logic [RES_WIDTH-1:0]  result;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;

  logic [DATA_WIDTH-1:0] ram     [32];
  logic [DATA_WIDTH-1:0] ref_mem [32];
  logic [ADDR_WIDTH-1:0] rd_log  [$];

  int total = 0;
  int bad   = 0;

  dot_product_ctrl_if mem_bus ();

  dot_product_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vec_a_sel   (vec_a_sel),
    .vec_b_sel   (vec_b_sel),
    .host_wr_en  (host_wr_en),
    .wr_rejected (wr_rejected),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mem         (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency; host writes land only when the DUT lets them.
  always @(posedge clk) begin
    if (mem_bus.mem_wr_en) ram[host_addr] <= host_data;
    if (mem_bus.mem_rd_en) mem_bus.mem_rd_data <= ram[mem_bus.mem_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int elem(input logic [DATA_WIDTH-1:0] x);
`ifdef DOT_PRODUCT_SIGNED_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  function automatic logic [31:0] model_dot(input int a, input int b);
    int acc = 0;
    logic [31:0] acc_bits;
    for (int i = 0; i < VEC_LEN; i++)
      acc += elem(ref_mem[a*VEC_LEN+i]) * elem(ref_mem[b*VEC_LEN+i]);
    acc_bits = acc;
    return {13'd0, acc_bits[RES_WIDTH-1:0]};
  endfunction

  task automatic host_write(input int addr, input logic [DATA_WIDTH-1:0] data);
    @(negedge clk);
    host_wr_en = 1'b1;
    host_addr  = ADDR_WIDTH'(addr);
    host_data  = data;
    @(posedge clk);
    #1;
    host_wr_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  // Starts a run and watches it: latency from the accepting edge, read-address trace,
  // and whether busy stayed high until the last MAC cycle.
  task automatic run_dp(input int a, input int b, output int lat, output int busy_err);
    @(negedge clk);
    start     = 1'b1;
    vec_a_sel = SEL_WIDTH'(a);
    vec_b_sel = SEL_WIDTH'(b);
    lat       = -1;
    busy_err  = 0;
    rd_log.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (mem_bus.mem_rd_en) rd_log.push_back(mem_bus.mem_rd_addr);
      if (cyc < 3*VEC_LEN && !busy) busy_err++;
      if (done) begin
        lat = cyc;
        if (busy) busy_err++;
        break;
      end
    end
  endtask

  int lat, busy_err, done_cnt;
  logic [31:0] exp_addr;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    vec_a_sel  = '0;
    vec_b_sel  = '0;
    host_wr_en = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_rd_en", 32'(mem_bus.mem_rd_en), 0);
    check("rst_rd_addr", 32'(mem_bus.mem_rd_addr), 0);
    check("rst_wr_rej", 32'(wr_rejected), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vec0 = 1..8, vec1 = 2, vec2 = vec3 = 255.
    for (int i = 0; i < 32; i++) begin
      if (i < 8)       host_write(i, DATA_WIDTH'(i + 1));
      else if (i < 16) host_write(i, 8'd2);
      else             host_write(i, 8'd255);
    end

    run_dp(0, 1, lat, busy_err);
    check("basic_latency", 32'(lat), 25);
    check("basic_result", 32'(result), 72);
    check("basic_model", 32'(result), model_dot(0, 1));
    check("basic_busy", 32'(busy_err), 0);
    check("basic_rd_count", 32'(rd_log.size()), 16);
    for (int i = 0; i < rd_log.size() && i < 16; i++) begin
      exp_addr = (i % 2 == 0) ? 32'(0*VEC_LEN + i/2) : 32'(1*VEC_LEN + i/2);
      check($sformatf("basic_rd_addr%0d", i), 32'(rd_log[i]), exp_addr);
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 0);

    run_dp(2, 3, lat, busy_err);
    check("full_scale_latency", 32'(lat), 25);
    check("full_scale_result", 32'(result), 32'h7F008);

    // start held for most of a square-norm run, then pulsed mid-run and in DONE.
    @(negedge clk);
    start     = 1'b1;
    vec_a_sel = 2'd0;
    vec_b_sel = 2'd0;
    done_cnt  = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      start = (cyc < 19) || (cyc == 21) || (cyc == 24);
    end
    check("hold_done_count", 32'(done_cnt), 1);
    check("hold_result", 32'(result), model_dot(0, 0));
    check("hold_idle_busy", 32'(busy), 0);

    // Write in the accepting cycle passes; the same write while busy is blocked.
    @(negedge clk);
    start      = 1'b1;
    vec_a_sel  = 2'd1;
    vec_b_sel  = 2'd1;
    host_wr_en = 1'b1;
    host_addr  = 5'd20;
    host_data  = 8'd7;
    #1;
    check("wr_on_accept", 32'(mem_bus.mem_wr_en), 1);
    @(posedge clk);
    #1;
    ref_mem[20] = 8'd7;
    start     = 1'b0;
    host_addr = 5'd3;
    host_data = 8'h55;
    #1;
    check("wr_busy_gated", 32'(mem_bus.mem_wr_en), 0);
    @(posedge clk);
    #1;
    host_wr_en = 1'b0;
    check("wr_rejected_pulse", 32'(wr_rejected), 1);
    @(posedge clk);
    #1;
    check("wr_rejected_clear", 32'(wr_rejected), 0);
    lat = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    check("wr_run_done_seen", 32'(lat >= 0), 1);
    check("wr_run_result", 32'(result), model_dot(1, 1));
    check("wr_mem3_kept", 32'(ram[3]), 32'(ref_mem[3]));
    check("wr_mem20_written", 32'(ram[20]), 7);
    host_write(3, 8'h55);
    check("wr_idle_pass", 32'(ram[3]), 32'h55);
    check("wr_idle_no_reject", 32'(wr_rejected), 0);

    // Synchronous reset at cycle 10 of a run.
    @(negedge clk);
    start     = 1'b1;
    vec_a_sel = 2'd2;
    vec_b_sel = 2'd3;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (cyc == 9) rst_n = 1'b0;
    end
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", 32'(result), 0);
    check("midrst_rd_en", 32'(mem_bus.mem_rd_en), 0);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 0);
    run_dp(0, 1, lat, busy_err);
    check("postrst_latency", 32'(lat), 25);
    check("postrst_result", 32'(result), model_dot(0, 1));

    // Vec0 = 0xFF, vec1 = 1: -8 when signed, 2040 when unsigned.
    for (int i = 0; i < 8; i++) host_write(i, 8'hFF);
    for (int i = 8; i < 16; i++) host_write(i, 8'h01);
    run_dp(0, 1, lat, busy_err);
    check("sign_case_result", 32'(result), model_dot(0, 1));

    // Random contents and selects, including a == b.
    for (int it = 0; it < 4; it++) begin
      int ra, rb;
      for (int i = 0; i < 32; i++) host_write(i, DATA_WIDTH'($urandom_range(0, 255)));
      ra = int'($urandom_range(0, NUM_VECTORS - 1));
      rb = (it == 3) ? ra : int'($urandom_range(0, NUM_VECTORS - 1));
      run_dp(ra, rb, lat, busy_err);
      check($sformatf("rand%0d_latency", it), 32'(lat), 25);
      check($sformatf("rand%0d_result", it), 32'(result), model_dot(ra, rb));
      check($sformatf("rand%0d_busy", it), 32'(busy_err), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
Sequencer that owns the read port of the dotProduct vector memory (depth 32, 4 vectors × 8 elements). On start it walks two selected vectors element by element, multiplies the pairs and accumulates them, then presents the result with a one-cycle done pulse. While it is busy it also gates host writes into the memory, so operands cannot change mid-computation.

Parameters:
DATA_WIDTH, 8, element width; must match the memory.
VEC_LEN, 8, elements per vector.
NUM_VECTORS, 4, vectors stored in memory.
ADDR_WIDTH, 5, memory address width; must satisfy 2**ADDR_WIDTH >= VEC_LEN*NUM_VECTORS.
SEL_WIDTH, 2, vector-select width, equal to clog2(NUM_VECTORS).
RES_WIDTH, 2*DATA_WIDTH+clog2(VEC_LEN) = 19, accumulator and result width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  request a dot product; sampled only in IDLE
vec_a_sel  in  SEL_WIDTH  index of vector A; captured when start is accepted
vec_b_sel  in  SEL_WIDTH  index of vector B; captured when start is accepted
host_wr_en  in  1  host write request to memory
mem_wr_en  out  1  write enable to memory, equal to host_wr_en & ~busy (combinational)
wr_rejected  out  1  registered; high for one cycle after host_wr_en was blocked by busy
mem_rd_en  out  1  memory read enable
mem_rd_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd_en
busy  out  1  high from start acceptance through the last MAC cycle
done  out  1  one-cycle pulse; result is valid
result  out  RES_WIDTH  dot product; holds its value until the next done

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-operation):
  - state goes to IDLE.
  - busy, done, wr_rejected, mem_rd_en and the accumulator are cleared to 0.
  - mem_rd_addr, result and the element index are cleared to 0.
- States: IDLE, RD_A, RD_B, MAC, DONE; registered, one-hot or binary.
- IDLE:
  - start=1 moves to RD_A.
  - On acceptance: latch both selects, clear the index and accumulator, set busy.
- RD_A: mem_rd_en=1 and mem_rd_addr = a_sel*VEC_LEN + idx. Next state RD_B.
- RD_B:
  - Capture mem_rd_data into op_a.
  - mem_rd_en=1 and mem_rd_addr = b_sel*VEC_LEN + idx.
  - Next state MAC.
- MAC:
  - acc <= acc + op_a*mem_rd_data, with the product zero-extended to RES_WIDTH.
  - If idx == VEC_LEN-1, go to DONE; otherwise increment idx and go to RD_A.
- DONE:
  - result <= acc; done=1 for exactly this cycle; busy=0.
  - Next state IDLE.
- mem_rd_en is 0 in IDLE, MAC and DONE.
- Latency: with start sampled at edge 0, done is high in the cycle after edge 3*VEC_LEN+1, i.e. 25 cycles for the defaults.
- Arithmetic: unsigned by default. The accumulator cannot overflow at RES_WIDTH; no saturation logic.
- start while busy or in DONE is ignored; it is not queued.
- vec_a_sel may equal vec_b_sel (square norm); this is legal.
- Write gating:
  - While busy=1, host_wr_en is suppressed and wr_rejected pulses the next cycle.
  - A write in the same cycle start is accepted is allowed, because busy is still 0 in that cycle.

Optional Feature:
DOT_PRODUCT_SIGNED_EN
- Defined: operands are two's complement. The product is sign-extended to RES_WIDTH and result is signed.
- Undefined: unsigned operation as described above.

Decomposition:
- Package dot_product_pkg holds:
  - the state enum (IDLE, RD_A, RD_B, MAC, DONE);
  - localparam RES_WIDTH;
  - the address-compute function base(sel) = sel*VEC_LEN.
- One sub-module, dot_mac:
  - Registered multiply-accumulate with clear and enable.
  - Signed/unsigned selection under DOT_PRODUCT_SIGNED_EN.
  - Output is the acc register.

Test Plan:
- Vec0 = 1..8, vec1 = all 2, start with a_sel=0, b_sel=1 -> done 25 cycles after start; result = 72; exactly 16 mem_rd_en pulses at addresses 0,8,1,9,...,7,15.
- Vec2 = vec3 = all 255, sel 2/3 -> result = 520200 (0x7F008); no overflow.
- start held high through the run, then pulsed again mid-run -> only one done; the second start is ignored; result is unchanged until a new start in IDLE.
- host_wr_en=1 during busy -> mem_wr_en=0, wr_rejected pulses the next cycle, memory is unchanged; the same write in IDLE passes through.
- rst_n=0 at cycle 10 of a run -> next cycle: busy=0, done=0, result=0, IDLE; a new start completes correctly.
- With DOT_PRODUCT_SIGNED_EN: vec0 = all 0xFF (−1), vec1 = all 1 -> result = −8 (0x7FFF8 at 19 bits).
